flag_pend_issue: RTL

FLAG_PEND_ISSUE -- requirements
Module: flag_pend_issue

---
 rtl/flag_pend_pkg.sv | 16 +
 rtl/flag_pend_issue_rr_arb.sv | 30 +++
 rtl/flag_pend_issue.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/flag_pend_pkg.sv
// Shared types and constants for the flag_pend_issue block.
// Optional issue-count statistics output is enabled by defining FLAG_PEND_STATS_EN.
package flag_pend_pkg;

    localparam int NSRC_DEF  = 4;
    localparam int CNT_W_DEF = 4;
    localparam int STATS_W   = 16;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        ARM,
        WAIT
    } state_e;

endpackage

// File: rtl/flag_pend_issue_rr_arb.sv
// Combinational round-robin arbiter: picks the lowest-index requester strictly
// above the last grant, wrapping to index 0.
module rr_arb
    import flag_pend_pkg::*;
#(
    parameter int NSRC  = NSRC_DEF,
    parameter int IDX_W = $clog2(NSRC)
) (
    input  logic [NSRC-1:0]  req_i,
    input  logic [IDX_W-1:0] last_i,
    output logic [IDX_W-1:0] gnt_o,
    output logic             gnt_vld_o
);

    logic [IDX_W-1:0] idx;

    always_comb begin
        gnt_o     = '0;
        gnt_vld_o = 1'b0;
        idx       = '0;
        for (int unsigned k = 1; k <= NSRC; k++) begin
            idx = IDX_W'((32'(last_i) + k) % NSRC);
            if (!gnt_vld_o && req_i[idx]) begin
                gnt_vld_o = 1'b1;
                gnt_o     = idx;
            end
        end
    end

endmodule

// File: rtl/flag_pend_issue.sv
// Per-source pending event counters feeding a single-pulse request handshake
// towards a flag synchronizer. Define FLAG_PEND_STATS_EN to add issued_cnt_o.
module flag_pend_issue
    import flag_pend_pkg::*;
#(
    parameter int NSRC  = NSRC_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NSRC-1:0]           evt_i,
    input  logic                      busy_i,
    input  logic                      ovf_clr_i,
    output logic                      flag_o,
    output logic [$clog2(NSRC)-1:0]   src_id_o,
    output logic                      pend_any_o,
    output logic [NSRC-1:0]           ovf_o
`ifdef FLAG_PEND_STATS_EN
   ,output logic [STATS_W-1:0]        issued_cnt_o
`endif
);

    localparam int IDX_W = $clog2(NSRC);

    state_e           state_q;
    logic             flag_q;
    logic [IDX_W-1:0] src_id_q;
    logic [IDX_W-1:0] last_q;

    logic [CNT_W-1:0] cnt_q [NSRC];
    logic [CNT_W-1:0] cnt_d [NSRC];
    logic [NSRC-1:0]  ovf_q;
    logic [NSRC-1:0]  ovf_d;
    logic [NSRC-1:0]  nz;
    logic [NSRC-1:0]  dec;
    logic             pend_any;

    logic [IDX_W-1:0] gnt;
    logic             gnt_vld;

    always_comb begin
        nz = '0;
        for (int unsigned i = 0; i < NSRC; i++) begin
            nz[i] = |cnt_q[i];
        end
    end

    assign pend_any = |nz;

    rr_arb #(
        .NSRC  (NSRC),
        .IDX_W (IDX_W)
    ) u_arb (
        .req_i     (nz),
        .last_i    (last_q),
        .gnt_o     (gnt),
        .gnt_vld_o (gnt_vld)
    );

    // src_id_q already holds the grant during ISSUE, so it selects the decrement.
    always_comb begin
        dec = '0;
        if (state_q == ISSUE) begin
            dec[src_id_q] = 1'b1;
        end
    end

    always_comb begin
        ovf_d = ovf_q & ~{NSRC{ovf_clr_i}};
        for (int unsigned i = 0; i < NSRC; i++) begin
            cnt_d[i] = cnt_q[i];
            if (evt_i[i] && !dec[i]) begin
                if (&cnt_q[i]) begin
                    ovf_d[i] = 1'b1;
                end else begin
                    cnt_d[i] = cnt_q[i] + CNT_W'(1);
                end
            end else if (dec[i] && !evt_i[i]) begin
                cnt_d[i] = cnt_q[i] - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < NSRC; i++) begin
                cnt_q[i] <= '0;
            end
            ovf_q <= '0;
        end else begin
            for (int unsigned i = 0; i < NSRC; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
            ovf_q <= ovf_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            flag_q   <= 1'b0;
            src_id_q <= '0;
            last_q   <= IDX_W'(NSRC - 1);
        end else begin
            flag_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (pend_any && gnt_vld && !busy_i) begin
                        state_q  <= ISSUE;
                        flag_q   <= 1'b1;
                        src_id_q <= gnt;
                        last_q   <= gnt;
                    end
                end
                ISSUE: state_q <= ARM;
                // The synchronizer raises busy one cycle after the pulse, so ARM skips it.
                ARM:   state_q <= WAIT;
                WAIT: begin
                    if (!busy_i) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

`ifdef FLAG_PEND_STATS_EN
    logic [STATS_W-1:0] issued_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            issued_q <= '0;
        end else if (state_q == ISSUE) begin
            issued_q <= issued_q + STATS_W'(1);
        end
    end

    assign issued_cnt_o = issued_q;
`endif

    assign flag_o     = flag_q;
    assign src_id_o   = src_id_q;
    assign pend_any_o = pend_any;
    assign ovf_o      = ovf_q;

endmodule
